// File: rtl/seven_segment_capture_pkg.sv
// Shared definitions for the 7-segment readback path: segment patterns
// (active-low, bit6=a .. bit0=g), 5-bit display codes and capture FSM states.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_N     = 7'b1101010;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [4:0] CODE_0       = 5'b00000;
    localparam logic [4:0] CODE_1       = 5'b00001;
    localparam logic [4:0] CODE_2       = 5'b00010;
    localparam logic [4:0] CODE_3       = 5'b00011;
    localparam logic [4:0] CODE_4       = 5'b00100;
    localparam logic [4:0] CODE_5       = 5'b00101;
    localparam logic [4:0] CODE_6       = 5'b00110;
    localparam logic [4:0] CODE_7       = 5'b00111;
    localparam logic [4:0] CODE_8       = 5'b01000;
    localparam logic [4:0] CODE_9       = 5'b01001;
    localparam logic [4:0] CODE_A       = 5'b01010;
    localparam logic [4:0] CODE_B       = 5'b01011;
    localparam logic [4:0] CODE_C       = 5'b01100;
    localparam logic [4:0] CODE_D       = 5'b01101;
    localparam logic [4:0] CODE_E       = 5'b01110;
    localparam logic [4:0] CODE_F       = 5'b01111;
    localparam logic [4:0] CODE_L       = 5'b10000;
    localparam logic [4:0] CODE_P       = 5'b10010;
    localparam logic [4:0] CODE_N       = 5'b10011;
    localparam logic [4:0] CODE_DASH    = 5'b10100;
    localparam logic [4:0] CODE_BLANK   = 5'b10101;
    localparam logic [4:0] CODE_INVALID = 5'b11111;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } cap_state_t;

endpackage

// File: rtl/seven_segment_capture_if.sv
// Frame handoff from the capture block (master) to its consumer (slave).
interface seven_segment_capture_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                    frame_valid;
    logic                    frame_ready;
    logic [5*NUM_DIGITS-1:0] frame_codes;
    logic [NUM_DIGITS-1:0]   frame_err;

    modport master (output frame_valid, frame_codes, frame_err, input frame_ready);
    modport slave  (input frame_valid, frame_codes, frame_err, output frame_ready);
endinterface

// File: rtl/seven_segment_capture_segment_to_binary.sv
// Combinational inverse of the display encoder: active-low segment pattern to
// 5-bit code. Unknown patterns give CODE_INVALID with o_err set.
module segment_to_binary
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [4:0] o_code,
    output logic       o_err
);

    always_comb begin
        o_code = CODE_INVALID;
        o_err  = 1'b0;
        case (i_seg)
            SEG_0:     o_code = CODE_0;
            SEG_1:     o_code = CODE_1;
            SEG_2:     o_code = CODE_2;
            SEG_3:     o_code = CODE_3;
            SEG_4:     o_code = CODE_4;
            SEG_5:     o_code = CODE_5;
            SEG_6:     o_code = CODE_6;
            SEG_7:     o_code = CODE_7;
            SEG_8:     o_code = CODE_8;
            SEG_9:     o_code = CODE_9;
            SEG_A:     o_code = CODE_A;
            SEG_B:     o_code = CODE_B;
            SEG_C:     o_code = CODE_C;
            // D and lowercase d share one pattern; the uppercase code wins
            SEG_D:     o_code = CODE_D;
            SEG_E:     o_code = CODE_E;
            SEG_F:     o_code = CODE_F;
            SEG_L:     o_code = CODE_L;
            SEG_P:     o_code = CODE_P;
            SEG_N:     o_code = CODE_N;
            SEG_DASH:  o_code = CODE_DASH;
            SEG_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code = CODE_INVALID;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Watches the multiplexed 7-segment drive, captures each digit once it has been
// stable long enough, and hands completed frames out over valid/ready.
//
// state   | meaning
// COLLECT | no frame held; collecting digits into the working buffer
// PENDING | frame held on the outputs awaiting frame_ready; still collecting
module seven_segment_capture
    import seg_pkg::*;
#(
    parameter int  NUM_DIGITS    = 4,
    parameter int  STABLE_CYCLES = 16,
    parameter int  CNT_W         = 8,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DIGITS-1:0]  an_in,
    input  logic [6:0]             seg_in,
    seven_segment_capture_if.master frame_if,
    output logic                   digit_strobe,
    output logic [IDX_W-1:0]       digit_idx,
    output logic                   overflow
);

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [5*NUM_DIGITS-1:0] r_buf_codes;
    logic [5*NUM_DIGITS-1:0] w_buf_codes;
    logic [5*NUM_DIGITS-1:0] r_frame_codes;
    logic [NUM_DIGITS-1:0]   r_buf_err;
    logic [NUM_DIGITS-1:0]   w_buf_err;
    logic [NUM_DIGITS-1:0]   r_frame_err;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [NUM_DIGITS-1:0]   w_seen;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        r_digit_idx;
    logic                    r_digit_strobe;
    logic                    r_overflow;
    logic [4:0]              w_code;
    logic                    w_err;
    logic                    w_valid;
    logic                    w_same;
    logic                    w_capture;
    logic                    w_complete;
    logic                    w_load;
    logic                    w_ovf_set;
    cap_state_t              r_state;
    cap_state_t              w_state_next;

    segment_to_binary u_decode (
        .i_seg  (r_seg),
        .o_code (w_code),
        .o_err  (w_err)
    );

    // The registered sample is held against the next incoming one, so the
    // count advances on the same edge that would have registered a change.
    assign w_valid   = $onehot(~r_an);
    assign w_same    = (an_in == r_an) && (seg_in == r_seg);
    assign w_capture = w_valid && w_same && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an[i]) w_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_valid || !w_same) begin
            w_cnt_next = '0;
        end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_buf_codes = r_buf_codes;
        w_buf_err   = r_buf_err;
        w_seen      = r_seen;
        if (w_capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    w_buf_codes[5*i +: 5] = w_code;
                    w_buf_err[i]          = w_err;
                    w_seen[i]             = 1'b1;
                end
            end
        end
    end

    assign w_complete = w_capture && (&w_seen);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                if (w_complete) begin
                    if (frame_if.frame_ready) w_load    = 1'b1;
                    else                      w_ovf_set = 1'b1;
                end else if (frame_if.frame_ready) begin
                    w_state_next = COLLECT;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= COLLECT;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an           <= '0;
            r_seg          <= '0;
            r_cnt          <= '0;
            r_buf_codes    <= '0;
            r_buf_err      <= '0;
            r_seen         <= '0;
            r_frame_codes  <= '0;
            r_frame_err    <= '0;
            r_digit_strobe <= 1'b0;
            r_digit_idx    <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_an           <= an_in;
            r_seg          <= seg_in;
            r_cnt          <= w_cnt_next;
            r_buf_codes    <= w_buf_codes;
            r_buf_err      <= w_buf_err;
            r_seen         <= w_complete ? '0 : w_seen;
            r_digit_strobe <= w_capture;
            if (w_capture) r_digit_idx <= w_idx;
            if (w_load) begin
                r_frame_codes <= w_buf_codes;
                r_frame_err   <= w_buf_err;
            end
            if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

    assign frame_if.frame_valid = (r_state == PENDING);
    assign frame_if.frame_codes = r_frame_codes;
    assign frame_if.frame_err   = r_frame_err;
    assign digit_strobe         = r_digit_strobe;
    assign digit_idx            = r_digit_idx;
    assign overflow             = r_overflow;

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
Readback side of the display path. It monitors the multiplexed 7-segment drive (active-low anodes plus active-low segments) and decodes each stable digit pattern back into its 5-bit display code. It assembles the digits into a frame and hands the frame to a consumer over a valid/ready handshake. It sits beside the display driver and is used for self-check and for echoing the display contents to the host.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anode width)
STABLE_CYCLES, 16, consecutive identical samples required before a digit is captured (must be at least 2)
CNT_W, 8, stability counter width (must be able to hold STABLE_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
an_in  input  NUM_DIGITS  anode select, active-low; bit i = digit i
seg_in  input  7  segments, active-low, bit6=a ... bit0=g
frame_ready  input  1  consumer accepts frame
frame_valid  output  1  frame_codes/frame_err hold a complete frame
frame_codes  output  5*NUM_DIGITS  digit i code at [5i+4:5i]
frame_err  output  NUM_DIGITS  bit i=1: digit i pattern unrecognised
digit_strobe  output  1  one-cycle pulse per captured digit
digit_idx  output  $clog2(NUM_DIGITS)  index of the digit captured with digit_strobe
overflow  output  1  sticky: a completed frame was dropped

Behaviour:
- Reset (async, active-high): every output 0; input registers, stability counter, working buffer and seen mask cleared; FSM to COLLECT. Reset mid-dwell or mid-frame discards partial data.
- Input stage: an_in and seg_in are registered once (an_r, seg_r). Both come from the same clk domain; there is no synchroniser.
- Sample validity: valid only when an_r has exactly one zero. All-high or multiple-low is invalid.
- Stability counter cnt, saturating at STABLE_CYCLES:
  - Cleared when the sample is invalid, or when (an_r, seg_r) differs from the previous cycle's registered sample.
  - Otherwise cnt increments.
  - A capture fires on the single cycle cnt becomes STABLE_CYCLES. A new dwell (sample change) is required before that digit can be recaptured.
- Latency: for inputs that change and then hold, digit_strobe asserts STABLE_CYCLES+1 rising edges after the change.
- Decode (combinational, applied to seg_r), pattern -> code:
  - 0000001->00000, 1001111->00001, 0010010->00010, 0000110->00011, 1001100->00100, 0100100->00101
  - 0100000->00110, 0001111->00111, 0000000->01000, 0000100->01001, 0001000->01010, 1100000->01011
  - 0110001->01100, 1000010->01101 (ambiguous D/d resolves to 01101; code 10001 is never produced), 0110000->01110, 0111000->01111
  - 1110001->10000, 0011000->10010, 1101010->10011, 1111110->10100, 1111111->10101 (blank)
  - Any other pattern -> code 11111 with err=1.
- Capture: writes code and err into working slot digit_idx and sets seen[digit_idx]. Recapturing a slot before frame completion overwrites it (latest wins).
- Frame completion: seen becomes all-ones, counting the capture in the current cycle.
- FSM COLLECT:
  - On frame completion: copy the working buffer to frame_codes/frame_err, frame_valid=1 next cycle, clear seen, go to PENDING.
- FSM PENDING:
  - Capture continues into the working buffer.
  - frame_valid && frame_ready: frame_valid=0 next cycle, go to COLLECT.
  - Frame completion while frame_valid && !frame_ready: the new frame is dropped, outputs are unchanged, overflow set, seen cleared.
  - Acceptance and completion in the same cycle: the new frame loads, frame_valid stays 1, no overflow.
- Output stability: frame_codes/frame_err are stable while frame_valid=1 and change only on load.
- overflow clears only on reset.

Decomposition:
- Shared package seg_pkg:
  - segment pattern constants (SEG_0..SEG_F, SEG_L, SEG_P, SEG_N, SEG_DASH, SEG_BLANK)
  - 5-bit code constants (CODE_0..CODE_BLANK)
  - CODE_INVALID = 5'b11111
  - FSM state enum {COLLECT, PENDING}
- Sub-module segment_to_binary: purely combinational, seg[6:0] -> code[4:0] and err. It is reused by the other readback/checker blocks.

Test Plan:
- Reset, then hold an_in=1110, seg_in=0000110 for 20 cycles -> one digit_strobe at edge 17, digit_idx=0; no frame_valid yet.
- Cycle digits 0..3 with 0000110, 0001000, 1111110, 1110001, 20 cycles each, frame_ready=1 -> frame_valid one cycle, frame_codes={10000,10100,01010,00011}, frame_err=0000.
- Digit 2 driven with 1010101, then a full frame -> frame_codes[14:10]=11111, frame_err=0100.
- Anode glitch 1100 or 1111 for 3 cycles between digits, dwell 10 cycles (< STABLE_CYCLES) -> no strobe, cnt restarts, no capture.
- frame_ready=0 across two full frames -> first frame held unchanged, overflow=1; raise frame_ready -> frame_valid drops next cycle, overflow stays 1.
- Assert reset mid-frame after 2 captures -> all outputs 0; the next frame requires all 4 digits again.
